// File: rtl/srl64_fifo_pkg.sv
// Shared sizing constants, types and occupancy update for the SRL64E-based FIFO.
package srl64_fifo_pkg;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned PTR_W = 6;
  localparam int unsigned CNT_W = 7;

  typedef logic [CNT_W-1:0] count_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Accepted operation in a cycle, bit 1 = write, bit 0 = read
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

  // Occupancy after one cycle given the accepted write/read strobes
  function automatic count_t next_count(input count_t count,
                                        input logic   wr_ok,
                                        input logic   rd_ok);
    op_e op;
    op = op_e'({wr_ok, rd_ok});
    case (op)
      OP_WR:   next_count = count + count_t'(1);
      OP_RD:   next_count = count - count_t'(1);
      default: next_count = count;
    endcase
  endfunction

endpackage

// File: rtl/srl64_fifo_bank.sv
// SRL64E adjustable-length shift register and a W-wide bank of them
// sharing address, clock enable and clock.

// One-bit, 64-tap shift register: D enters tap 0, Q reads tap A combinationally.
module SRL64E (
  input  logic       CLK,
  input  logic       CE,
  input  logic [5:0] A,
  input  logic       D,
  output logic       Q
);

  logic [63:0] sr;

  // Shift the new bit into tap 0 when enabled; contents are never cleared
  always_ff @(posedge CLK) begin
    if (CE) sr <= {sr[62:0], D};
  end

  assign Q = sr[A];

endmodule

module srl64_bank #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         ce,
  input  logic [5:0]   a,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    SRL64E u_srl (
      .CLK (clk),
      .CE  (ce),
      .A   (a),
      .D   (d[i]),
      .Q   (q[i])
    );
  end

endmodule

// File: rtl/srl64_fifo.sv
// First-word-fall-through FIFO, 64 deep, reading the oldest word out of an
// SRL64E bank by steering its tap address to COUNT-1.
module srl64_fifo
  import srl64_fifo_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned AF_LEVEL = 48,
  parameter int unsigned AE_LEVEL = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] D,
  input  logic         WE,
  input  logic         RE,
  output logic [W-1:0] Q,
  output logic         EMPTY,
  output logic         FULL,
  output logic         ALMOST_FULL,
  output logic         ALMOST_EMPTY,
  output logic [6:0]   COUNT,
  output logic         OVF,
  output logic         UNF
);

  localparam count_t AF_C   = count_t'(AF_LEVEL);
  localparam count_t AE_C   = count_t'(AE_LEVEL);
  localparam count_t FULL_C = count_t'(DEPTH);

  count_t count;
  count_t count_nxt;
  ptr_t   ptr;
  ptr_t   ptr_nxt;
  logic   wr_ok;
  logic   rd_ok;

  // Accept decisions: a write into a full FIFO is only allowed alongside a read
  always_comb begin
    wr_ok = WE & (~FULL | RE);
    rd_ok = RE & ~EMPTY;
  end

  // Next occupancy and tap address of the oldest word after this edge
  always_comb begin
    count_nxt = next_count(count, wr_ok, rd_ok);
    ptr_nxt   = '0;
    if (count_nxt != '0) ptr_nxt = ptr_t'(count_nxt - count_t'(1));
  end

  // Occupancy, pointer, flags and error pulses, all decoded from next count
  always_ff @(posedge CLK) begin
    if (RST) begin
      count        <= '0;
      ptr          <= '0;
      EMPTY        <= 1'b1;
      FULL         <= 1'b0;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVF          <= 1'b0;
      UNF          <= 1'b0;
    end else begin
      count        <= count_nxt;
      ptr          <= ptr_nxt;
      EMPTY        <= (count_nxt == '0);
      FULL         <= (count_nxt == FULL_C);
      ALMOST_FULL  <= (count_nxt >= AF_C);
      ALMOST_EMPTY <= (count_nxt <= AE_C);
      OVF          <= WE & FULL & ~RE;
      UNF          <= RE & EMPTY;
    end
  end

  assign COUNT = count;

  // A reset cycle must not shift, so stored data stays untouched across it
  srl64_bank #(.W(W)) u_bank (
    .clk (CLK),
    .ce  (wr_ok & ~RST),
    .a   (ptr),
    .d   (D),
    .q   (Q)
  );

endmodule

// File: tb/tb_srl64_fifo.sv
// Directed self-checking bench for srl64_fifo.
module tb_srl64_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       we;
  logic       re;
  logic [7:0] q;
  logic       empty, full, afull, aempty, ovf, unf;
  logic [6:0] count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  srl64_fifo #(.W(8), .AF_LEVEL(48), .AE_LEVEL(16)) dut (
    .CLK          (clk),
    .RST          (rst),
    .D            (d),
    .WE           (we),
    .RE           (re),
    .Q            (q),
    .EMPTY        (empty),
    .FULL         (full),
    .ALMOST_FULL  (afull),
    .ALMOST_EMPTY (aempty),
    .COUNT        (count),
    .OVF          (ovf),
    .UNF          (unf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; d = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got=%b exp=1", aempty); end
    checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", afull); end
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL reset_ovf_unf got=%b exp=00", {ovf, unf}); end
    checks++; if (dut.ptr !== 6'd0) begin errors++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; d = vals[i];
      step();
    end
    we = 1'b0;
    checks++; if (count !== 7'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", count); end
    checks++; if (dut.ptr !== 6'd2) begin errors++; $display("FAIL basic_ptr got=%0d exp=2", dut.ptr); end
    checks++; if (q !== 8'h11) begin errors++; $display("FAIL basic_q0 got=%h exp=11", q); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", empty); end
    re = 1'b1;
    step();
    checks++; if (q !== 8'h22) begin errors++; $display("FAIL basic_q1 got=%h exp=22", q); end
    step();
    checks++; if (q !== 8'h33) begin errors++; $display("FAIL basic_q2 got=%h exp=33", q); end
    step();
    re = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_drain_empty got=%b exp=1", empty); end
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL basic_drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill_ovf();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      we = 1'b1; d = 8'(i);
      step();
      checks++;
      if (afull !== (i + 1 >= 48) || full !== (i + 1 == 64) || aempty !== (i + 1 <= 16) || count !== 7'(i + 1)) begin
        errors++;
        $display("FAIL fill_flags n=%0d got count=%0d af=%b f=%b ae=%b exp af=%b f=%b ae=%b",
                 i + 1, count, afull, full, aempty, (i + 1 >= 48), (i + 1 == 64), (i + 1 <= 16));
      end
    end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL fill_q got=%h exp=00", q); end
    d = 8'hFF;
    step();
    we = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", ovf); end
    checks++; if (count !== 7'd64) begin errors++; $display("FAIL ovf_count got=%0d exp=64", count); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL ovf_q got=%h exp=00", q); end
    step();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask

  // Continues from a full FIFO holding 0x00..0x3F
  task automatic test_full_rw();
    we = 1'b1; re = 1'b1; d = 8'h40;
    step();
    we = 1'b0; re = 1'b0;
    checks++; if (count !== 7'd64) begin errors++; $display("FAIL fullrw_count got=%0d exp=64", count); end
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL fullrw_q got=%h exp=01", q); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got=%b exp=0", ovf); end
    re = 1'b1;
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (q !== 8'(k + 1)) begin errors++; $display("FAIL drain_q idx=%0d got=%h exp=%h", k, q, 8'(k + 1)); end
      step();
    end
    re = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; d = 8'(8'h80 + i);
      step();
    end
    re = 1'b1;
    for (int j = 0; j < 20; j++) begin
      d = 8'(8'h85 + j);
      checks++;
      if (q !== 8'(8'h80 + j)) begin errors++; $display("FAIL b2b_q cyc=%0d got=%h exp=%h", j, q, 8'(8'h80 + j)); end
      step();
      checks++;
      if (count !== 7'd5 || dut.ptr !== 6'd4) begin
        errors++; $display("FAIL b2b_level cyc=%0d got count=%0d ptr=%0d exp count=5 ptr=4", j, count, dut.ptr);
      end
    end
    we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q !== 8'(8'h94 + k)) begin errors++; $display("FAIL b2b_tail idx=%0d got=%h exp=%h", k, q, 8'(8'h94 + k)); end
      step();
    end
    re = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    do_reset();
    re = 1'b1;
    step();
    re = 1'b0;
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL unf_solo got=%b exp=1", unf); end
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL unf_solo_count got=%0d exp=0", count); end
    we = 1'b1; re = 1'b1; d = 8'hA5;
    step();
    we = 1'b0; re = 1'b0;
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL unf_rw got=%b exp=1", unf); end
    checks++; if (count !== 7'd1) begin errors++; $display("FAIL unf_rw_count got=%0d exp=1", count); end
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL unf_rw_q got=%h exp=a5", q); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL unf_rw_empty got=%b exp=0", empty); end
    step();
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL unf_clear got=%b exp=0", unf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      we = 1'b1; d = 8'(8'hC0 + i);
      step();
    end
    checks++; if (count !== 7'd30) begin errors++; $display("FAIL mid_pre_count got=%0d exp=30", count); end
    rst = 1'b1; we = 1'b1; re = 1'b1;
    step();
    rst = 1'b0; we = 1'b0; re = 1'b0;
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty); end
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL mid_ovf_unf got=%b exp=00", {ovf, unf}); end
    we = 1'b1; d = 8'h5A;
    step();
    we = 1'b0;
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL mid_q got=%h exp=5a", q); end
    checks++; if (count !== 7'd1) begin errors++; $display("FAIL mid_after_count got=%0d exp=1", count); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; d = '0;
    test_reset();
    test_basic();
    test_fill_ovf();
    test_full_rw();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
